// File: rtl/hvtx_pkg.sv
// Shared types for the HDMI TX raster feed: pixel payload, feed FSM states
// and the FIFO word that carries the start-of-frame marker with each pixel.
package hvtx_pkg;

    localparam int unsigned PIXEL_W = 24;

    typedef logic [2:0][7:0] pixel_t;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } feed_state_t;

    typedef struct packed {
        logic   sof;
        pixel_t pixel;
    } fifo_word_t;

endpackage

// File: rtl/hvtx_fifo.sv
// Synchronous FIFO holding {sof, pixel} words between producer and raster.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_wdata write
// side; i_pop read side; o_head current head word; o_empty/o_full flags;
// o_count occupancy (0..DEPTH).
module hvtx_fifo
    import hvtx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  fifo_word_t               i_wdata,
    input  logic                     i_pop,
    output fifo_word_t               o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    fifo_word_t    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_count   = r_wptr - r_rptr;
    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == PW'(DEPTH));
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage; a word written this cycle is visible at the head next cycle.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/hvtx_raster_feed.sv
// Raster-aligned pixel feed for the TMDS modulator. Buffers a valid/ready
// pixel stream and pops one pixel per active (x, y), registering the result
// so it lines up with the sync stage's registered data-enable.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_x/i_y cursor;
// i_valid/o_ready/i_sof/i_pixel producer stream; o_video pixel out;
// o_locked feed in RUN; o_underflow one-cycle pulse; o_err_cnt saturating
// underflow + misalign count.
module hvtx_raster_feed
    import hvtx_pkg::*;
#(
    parameter int unsigned       WIDTH         = 12,
    parameter logic [WIDTH-1:0]  ACTIVE_WIDTH  = WIDTH'(1280),
    parameter logic [WIDTH-1:0]  ACTIVE_HEIGHT = WIDTH'(720),
    parameter int unsigned       DEPTH         = 16,
    parameter pixel_t            FILL_COLOR    = 24'h000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sof,
    input  pixel_t           i_pixel,
    output pixel_t           o_video,
    output logic             o_locked,
    output logic             o_underflow,
    output logic [7:0]       o_err_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    feed_state_t r_state;
    pixel_t      r_video;
    logic        r_ready;
    logic        r_locked;
    logic        r_underflow;
    logic [7:0]  r_err_cnt;

    fifo_word_t  w_head;
    fifo_word_t  w_wdata;
    logic        w_empty;
    logic        w_full;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_show;
    logic        w_need;
    logic        w_origin;
    logic        w_uflow;
    logic        w_err_evt;
    feed_state_t w_state_nxt;

    assign w_need    = (i_x < ACTIVE_WIDTH) && (i_y < ACTIVE_HEIGHT);
    assign w_origin  = (i_x == '0) && (i_y == '0);
    assign w_push    = i_valid && r_ready && !w_full;
    assign w_wdata   = '{sof: i_sof, pixel: i_pixel};
    // Ready looks one cycle ahead so a full FIFO never sees another push.
    assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);

    hvtx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Feed decisions: pop strobe, error events and next state.
    always_comb begin
        w_pop       = 1'b0;
        w_show      = 1'b0;
        w_uflow     = 1'b0;
        w_err_evt   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            SEEK: begin
                // Drain everything up to the next frame start.
                if (!w_empty) begin
                    if (w_head.sof) w_state_nxt = ARMED;
                    else            w_pop       = 1'b1;
                end
            end
            ARMED: begin
                if (w_origin && !w_empty) begin
                    w_pop       = 1'b1;
                    w_show      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_need) begin
                    if (w_empty) begin
                        w_uflow     = 1'b1;
                        w_err_evt   = 1'b1;
                        w_state_nxt = SEEK;
                    end else if (w_origin && !w_head.sof) begin
                        w_err_evt   = 1'b1;
                        w_state_nxt = SEEK;
                    end else if (!w_origin && w_head.sof) begin
                        // Frame came up short: keep the new frame's head for the next origin.
                        w_err_evt   = 1'b1;
                        w_state_nxt = ARMED;
                    end else begin
                        w_pop  = 1'b1;
                        w_show = 1'b1;
                    end
                end
            end
            default: w_state_nxt = SEEK;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEEK;
            r_video     <= FILL_COLOR;
            r_ready     <= 1'b0;
            r_locked    <= 1'b0;
            r_underflow <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_video     <= w_show ? w_head.pixel : FILL_COLOR;
            r_ready     <= (w_cnt_nxt != CW'(DEPTH));
            r_locked    <= (w_state_nxt == RUN);
            r_underflow <= w_uflow;
            if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_video     = r_video;
    assign o_ready     = r_ready;
    assign o_locked    = r_locked;
    assign o_underflow = r_underflow;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_hvtx_raster_feed.sv
// Directed bench for hvtx_raster_feed on a 12x6 raster with an 8x4 active area.
module tb_hvtx_raster_feed;
    import hvtx_pkg::*;

    localparam int unsigned WIDTH = 12;
    localparam int HT = 12;
    localparam int VT = 6;
    localparam int AW = 8;
    localparam int AH = 4;
    localparam int NEVER = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             ready;
    logic             sof;
    pixel_t           pixel;
    pixel_t           video;
    logic             locked;
    logic             uflow;
    logic [7:0]       err;

    always #5 clk = ~clk;

    hvtx_raster_feed #(
        .WIDTH         (WIDTH),
        .ACTIVE_WIDTH  (12'd8),
        .ACTIVE_HEIGHT (12'd4),
        .DEPTH         (8),
        .FILL_COLOR    (24'h000000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x),
        .i_y         (y),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_sof       (sof),
        .i_pixel     (pixel),
        .o_video     (video),
        .o_locked    (locked),
        .o_underflow (uflow),
        .o_err_cnt   (err)
    );

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [23:0] video;
        logic        locked;
        logic [7:0]  err;
        logic        uflow;
    } vec_t;

    typedef struct packed {
        logic        sof;
        logic [23:0] pix;
    } item_t;

    vec_t  vtab[$];
    item_t pq[$];
    int    n_vec;
    int    n_mis;
    int    n_acc;
    bit    offer_acc;
    bit    prev_on;
    int    prev_f, prev_x, prev_y;

    // Expected outputs per raster position. Frame 0 runs correctly until
    // linear position pu; frame 1 is a clean relocked frame.
    function automatic void fill_tab(input int nf, input int pu, input bit is_uf,
                                     input int b0, input int b1);
        vec_t v;
        int   p;
        int   idx;
        bit   act;
        bit   bad;
        vtab.delete();
        for (int f = 0; f < nf; f++) begin
            for (int yy = 0; yy < VT; yy++) begin
                for (int xx = 0; xx < HT; xx++) begin
                    p   = yy * HT + xx;
                    idx = yy * AW + xx;
                    act = (xx < AW) && (yy < AH);
                    v.f = f; v.x = xx; v.y = yy;
                    if (f == 0) begin
                        bad      = (p >= pu);
                        v.locked = !bad;
                        v.err    = bad ? 8'd1 : 8'd0;
                        v.uflow  = is_uf && (p == pu);
                        v.video  = (act && !bad) ? 24'(b0 + idx) : 24'h0;
                    end else begin
                        v.locked = 1'b1;
                        v.err    = (pu < NEVER) ? 8'd1 : 8'd0;
                        v.uflow  = 1'b0;
                        v.video  = act ? 24'(b1 + idx) : 24'h0;
                    end
                    vtab.push_back(v);
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pos(input int f, input int cx, input int cy);
        foreach (vtab[i]) begin
            if (vtab[i].f == f && vtab[i].x == cx && vtab[i].y == cy) begin
                n_vec++;
                if (video !== vtab[i].video || locked !== vtab[i].locked ||
                    err !== vtab[i].err || uflow !== vtab[i].uflow) begin
                    n_mis++;
                    $display("FAIL vec f%0d x%0d y%0d: got video=%h locked=%b err=%0d uflow=%b, expected video=%h locked=%b err=%0d uflow=%b",
                             f, cx, cy, video, locked, err, uflow,
                             vtab[i].video, vtab[i].locked, vtab[i].err, vtab[i].uflow);
                end
            end
        end
    endtask

    task automatic push_items(input int base, input int n, input bit with_sof);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.sof = with_sof && (i == 0);
            it.pix = 24'(base + i);
            pq.push_back(it);
        end
    endtask

    // One cycle: check output of the previous position, advance the producer,
    // drive the next cursor position.
    task automatic step(input bit pos_on, input int f, input int px, input int py);
        @(negedge clk);
        if (prev_on) check_pos(prev_f, prev_x, prev_y);
        if (offer_acc) begin
            void'(pq.pop_front());
            n_acc++;
        end
        if (pq.size() > 0) begin
            valid     = 1'b1;
            sof       = pq[0].sof;
            pixel     = pq[0].pix;
            offer_acc = ready;
        end else begin
            valid     = 1'b0;
            sof       = 1'b0;
            pixel     = '0;
            offer_acc = 1'b0;
        end
        x = WIDTH'(px);
        y = WIDTH'(py);
        prev_on = pos_on; prev_f = f; prev_x = px; prev_y = py;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 8, 5);
    endtask

    task automatic run_raster(input int nf, input int start_p, input int stop_f,
                              input int stop_p, input int refill_p, input int refill_base);
        for (int f = 0; f < nf; f++) begin
            for (int p = (f == 0) ? start_p : 0; p < HT * VT; p++) begin
                if (f == 0 && p == refill_p) push_items(refill_base, AW * AH, 1'b1);
                step(1'b1, f, p % HT, p / HT);
                if (f == stop_f && p == stop_p) return;
            end
        end
        step(1'b0, 0, 8, 5);
    endtask

    task automatic clear_tb();
        pq.delete();
        offer_acc = 1'b0;
        prev_on   = 1'b0;
        n_acc     = 0;
        valid     = 1'b0;
        sof       = 1'b0;
        pixel     = '0;
        x         = WIDTH'(8);
        y         = WIDTH'(5);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        rst_n = 1'b0;
        clear_tb();

        // Reset values and ready coming up after release
        repeat (2) @(negedge clk);
        chk("rst_video", 32'(video), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_uflow", 32'(uflow), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(ready), 32'h1);

        // Lock and two clean frames
        do_reset();
        push_items(1, 32, 1'b1);
        push_items(1, 32, 1'b1);
        fill_tab(2, NEVER, 1'b0, 1, 1);
        idle(16);
        run_raster(2, 0, -1, -1, -1, 0);

        // Leading garbage discarded in SEEK
        do_reset();
        push_items(100, 3, 1'b0);
        push_items(1, 32, 1'b1);
        fill_tab(1, NEVER, 1'b0, 1, 0);
        idle(20);
        run_raster(1, 0, -1, -1, -1, 0);

        // Underflow at pixel 21 (x=4,y=2), relock on refilled frame
        do_reset();
        push_items(1, 20, 1'b1);
        fill_tab(2, 2 * HT + 4, 1'b1, 1, 1);
        idle(16);
        run_raster(2, 0, -1, -1, 3 * HT + 4, 1);

        // Short frame: misalign at x=7,y=3, next frame shows from origin
        do_reset();
        push_items(1, 31, 1'b1);
        push_items(101, 32, 1'b1);
        fill_tab(2, 3 * HT + 7, 1'b0, 1, 101);
        idle(16);
        run_raster(2, 0, -1, -1, -1, 0);

        // Backpressure while held in blanking
        do_reset();
        push_items(1, 32, 1'b1);
        fill_tab(1, NEVER, 1'b0, 1, 0);
        repeat (20) step(1'b0, 0, 8, 0);
        chk("bp_accepted", 32'(n_acc), 32'd8);
        chk("bp_ready_low", 32'(ready), 32'h0);
        step(1'b1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("bp_ready_after_pop", 32'(ready), 32'h1);
        run_raster(1, 1, -1, -1, -1, 0);

        // Asynchronous reset mid-RUN at x=3,y=1 of the relocked frame
        do_reset();
        push_items(1, 31, 1'b1);
        push_items(101, 32, 1'b1);
        fill_tab(2, 3 * HT + 7, 1'b0, 1, 101);
        idle(16);
        run_raster(2, 0, 1, HT + 3, -1, 0);
        chk("pre_rst_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_video", 32'(video), 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_uflow", 32'(uflow), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        clear_tb();
        repeat (2) @(negedge clk);
        chk("mid_rst_ready_held", 32'(ready), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_release", 32'(ready), 32'h1);
        repeat (4) step(1'b0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_seek_locked", 32'(locked), 32'h0);
        chk("post_rst_seek_video", 32'(video), 32'h0);
        chk("post_rst_seek_uflow", 32'(uflow), 32'h0);
        push_items(201, 32, 1'b1);
        fill_tab(1, NEVER, 1'b0, 201, 0);
        idle(16);
        run_raster(1, 0, -1, -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
